mux_nway_pipe: RTL and testbench

//  Parametrised N-channel, WIDTH-bit registered selector with valid/ready handshakes.

---
 rtl/mux_nway_pipe.sv | 111 +++++++++++
 tb/tb_mux_nway_pipe.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mux_nway_pipe.sv
// N-channel registered selector with valid/ready handshakes.
// Fixed-select or round-robin grant feeds a single output register.
module mux_nway_pipe #(
  parameter  int WIDTH    = 5,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    r_data_p1;
  logic [SEL_W-1:0]    r_chan_p1;
  logic                r_vld_p1;
  logic [SEL_W-1:0]    r_rr_ptr;

  logic                w_load_en;
  logic                w_grant_vld;
  logic [SEL_W-1:0]    w_grant;
  logic [SEL_W-1:0]    w_rr_next;
  logic [WIDTH-1:0]    w_sel_data;
  logic [CHANNELS-1:0] w_in_ready;
  logic                w_xfer;

  assign w_load_en = rst_n && (!r_vld_p1 || out_ready);

  // Round-robin scan runs from the far end back toward rr_ptr so the
  // nearest valid channel is the last (winning) assignment.
  always_comb begin
    int sel_i;
    int idx;
    logic [SEL_W-1:0] w_idx;
    sel_i       = int'(sel);
    idx         = 0;
    w_idx       = '0;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    if (!mode) begin
      if (sel_i < CHANNELS) begin
        if (in_valid[sel]) begin
          w_grant_vld = 1'b1;
          w_grant     = sel;
        end
      end
    end else begin
      for (int k = CHANNELS-1; k >= 0; k--) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        w_idx = SEL_W'(idx);
        if (in_valid[w_idx]) begin
          w_grant_vld = 1'b1;
          w_grant     = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_in_ready = '0;
    if (w_load_en && w_grant_vld) w_in_ready[w_grant] = 1'b1;
  end

  // Data mux uses constant slices only; in_data reaches nothing but the register.
  always_comb begin
    w_sel_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (SEL_W'(c) == w_grant) w_sel_data = in_data[c*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    if (int'(w_grant) == CHANNELS-1) w_rr_next = '0;
    else                             w_rr_next = w_grant + 1'b1;
  end

  assign w_xfer = w_load_en && w_grant_vld;

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p1 <= '0;
      r_chan_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_rr_ptr  <= '0;
    end else begin
      if (w_xfer) begin
        r_data_p1 <= w_sel_data;
        r_chan_p1 <= w_grant;
        r_vld_p1  <= 1'b1;
        if (mode) r_rr_ptr <= w_rr_next;
      end else if (r_vld_p1 && out_ready) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_data_p1;
  assign out_chan  = r_chan_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_mux_nway_pipe.sv
// Directed-vector bench for mux_nway_pipe (WIDTH=5, CHANNELS=4).
module tb_mux_nway_pipe;
  localparam int WIDTH    = 5;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  int n_vec = 0;
  int n_err = 0;

  mux_nway_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [WIDTH-1:0] v);
    in_data[c*WIDTH +: WIDTH] = v;
  endtask

  task automatic chk_out(input string tag, input int d, input int c, input int v);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_chan"},  32'(out_chan),  32'(c));
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    step();
    chk_out("rst0", 0, 0, 0);
    chk("rst0_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    // T2: fixed select channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0110; out_ready = 1'b1;
    set_ch(1, 5'd9); set_ch(2, 5'd17);
    #1;
    chk("t2_ready", 32'(in_ready), 32'b0100);
    step();
    chk_out("t2_out", 17, 2, 1);

    // T3: selected channel not valid -> drain only
    sel = 2'd3; in_valid = 4'b0111;
    #1;
    chk("t3_ready", 32'(in_ready), 32'd0);
    step();
    chk_out("t3_drain", 17, 2, 0);

    // T4: round-robin fairness, all valid
    mode = 1'b1; in_valid = 4'b1111;
    set_ch(0, 5'd1); set_ch(1, 5'd2); set_ch(2, 5'd3); set_ch(3, 5'd4);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out($sformatf("t4_%0d", i), (i % 4) + 1, i % 4, 1);
    end

    // T5: move rr_ptr to 3 via a grant on ch2, then check the wrap
    in_valid = 4'b0100;
    #1;
    chk("t5_pre_ready", 32'(in_ready), 32'b0100);
    step();
    chk_out("t5_pre", 3, 2, 1);
    in_valid = 4'b0101;
    #1;
    chk("t5_wrap_ready", 32'(in_ready), 32'b0001);
    step();
    chk_out("t5_wrap", 1, 0, 1);
    #1;
    chk("t5_next_ready", 32'(in_ready), 32'b0100);
    step();
    chk_out("t5_next", 3, 2, 1);

    // T6: stall for 3 cycles with new data offered, then drain+reload
    out_ready = 1'b0; in_valid = 4'b1111;
    set_ch(0, 5'd10); set_ch(1, 5'd11); set_ch(2, 5'd12); set_ch(3, 5'd13);
    #1;
    chk("t6_stall_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("t6_stall%0d", i), 3, 2, 1);
      chk($sformatf("t6_stall%0d_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t6_release_ready", 32'(in_ready), 32'b1000);
    step();
    chk_out("t6_reload", 13, 3, 1);

    // T1: asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t1_async", 0, 0, 0);
    chk("t1_ready", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t1_rrptr_ready", 32'(in_ready), 32'b0001);
    step();
    chk_out("t1_after", 10, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
